// File: rtl/mic_pkg.sv
// Shared types and default sizes for the microphone ADC front end.
package mic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } mic_adc_state_t;

  localparam int MIC_SAMPLE_WIDTH = 32;
  localparam int MIC_ADC_BITS     = 12;
  localparam int MIC_FRAME_BITS   = 16;

endpackage

// File: rtl/mic_sclk_gen.sv
// Half-period counter for the ADC serial clock. While enabled it toggles the
// registered sclk every CLK_DIV cycles and flags the last cycle of each phase.
// Disabled, it parks with sclk low and the counter cleared.
module mic_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic phase_done_o,
  output logic adc_sclk_o
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          last;

  assign last         = (cnt_q == CW'(CLK_DIV - 1));
  assign phase_done_o = en_i && last;
  assign adc_sclk_o   = sclk_q;

  // Next half-period count and sclk level.
  always_comb begin
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (en_i) begin
      cnt_d  = last ? '0 : cnt_q + CW'(1);
      sclk_d = last ? ~sclk_q : sclk_q;
    end
  end

  // Counter and sclk registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/mic_adc_reader.sv
// Serial ADC reader: paces conversions from a sample-period counter, drives
// chip select and sclk, shifts each frame in MSB first and strobes the result.
// Optional MIC_ADC_TWOS_COMP_EN: treat the ADC word as offset binary and
// convert it to a sign-extended two's-complement sample. Default build
// zero-extends the raw ADC word.
module mic_adc_reader
  import mic_pkg::*;
#(
  parameter int WIDTH         = MIC_SAMPLE_WIDTH,
  parameter int DATA_BITS     = MIC_ADC_BITS,
  parameter int FRAME_BITS    = MIC_FRAME_BITS,
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             adc_dout,
  output logic             adc_cs_n,
  output logic             adc_sclk,
  output logic [WIDTH-1:0] sample,
  output logic             sample_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int SW = $clog2(CLK_DIV + 1);

  mic_adc_state_t       state_q, state_d;
  logic [PW-1:0]        per_q, per_d;
  logic [SW-1:0]        setup_q, setup_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 cs_n_q, cs_n_d;
  logic [WIDTH-1:0]     sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;

  logic                 tick;
  logic                 sclk_en;
  logic                 phase_done;
  logic [WIDTH-1:0]     fmt;

  // Only the last DATA_BITS shifted bits survive, so the leading frame bits
  // fall off the top of the shift register on their own.
`ifdef MIC_ADC_TWOS_COMP_EN
  logic [DATA_BITS-1:0] word;
  assign word = {~sh_q[DATA_BITS-1], sh_q[DATA_BITS-2:0]};
  assign fmt  = WIDTH'($signed(word));
`else
  assign fmt  = WIDTH'(sh_q);
`endif

  assign tick    = enable && (per_q == '0);
  assign sclk_en = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);

  mic_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk          (clk),
    .reset        (reset),
    .en_i         (sclk_en),
    .phase_done_o (phase_done),
    .adc_sclk_o   (adc_sclk)
  );

  // Period counter, frame sequencing, shifting and output formatting.
  always_comb begin
    state_d  = state_q;
    setup_d  = setup_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    cs_n_d   = cs_n_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    ovr_d    = ovr_q | (tick && (state_q != ST_IDLE));
    per_d    = '0;
    if (enable)
      per_d = (per_q == PW'(SAMPLE_PERIOD - 1)) ? '0 : per_q + PW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_SETUP;
          cs_n_d  = 1'b0;
          setup_d = '0;
          bit_d   = '0;
        end
      end
      ST_SETUP: begin
        if (setup_q == SW'(CLK_DIV - 1)) state_d = ST_SHIFT_LO;
        else                             setup_d = setup_q + SW'(1);
      end
      ST_SHIFT_LO: begin
        if (phase_done) begin
          sh_d    = {sh_q[DATA_BITS-2:0], adc_dout};
          bit_d   = bit_q + BW'(1);
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_done) begin
          if (bit_q == BW'(FRAME_BITS)) begin
            state_d  = ST_DONE;
            cs_n_d   = 1'b1;
            valid_d  = 1'b1;
            sample_d = fmt;
          end else begin
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      per_q    <= '0;
      setup_q  <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      cs_n_q   <= 1'b1;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      setup_q  <= setup_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      cs_n_q   <= cs_n_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign busy         = ~cs_n_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: doc/mic_adc_reader.md
# mic_adc_reader

Serial ADC front end for the microphone path. It paces conversions from a programmable sample-period counter and drives the ADC chip-select and serial clock. It shifts in each conversion frame MSB first and presents the result as a WIDTH-bit word with a one-cycle valid strobe. It sits directly upstream of the N-sample capture/window stage, which consumes `sample` / `sample_valid`.

## Interface
- `WIDTH`, 32: output sample width; must be ≥ DATA_BITS.
- `DATA_BITS`, 12: ADC resolution; these are the last DATA_BITS bits of the frame.
- `FRAME_BITS`, 16: serial clocks per conversion (leading bits + data); must be ≥ DATA_BITS.
- `CLK_DIV`, 2: `clk` cycles per half-period of `adc_sclk`; must be ≥ 1.
- `SAMPLE_PERIOD`, 100: `clk` cycles between conversion starts; must be ≥ CLK_DIV*(2*FRAME_BITS+1)+2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  conversions start only while high.
- `adc_dout`  in  1  ADC serial data; already synchronous to `clk`.
- `adc_cs_n`  out  1  ADC chip select, active low.
- `adc_sclk`  out  1  ADC serial clock; idles low.
- `sample`  out  WIDTH  last completed conversion; held between strobes.
- `sample_valid`  out  1  one-cycle pulse when `sample` updates.
- `busy`  out  1  high while a frame is in progress (`adc_cs_n` low).
- `overrun`  out  1  sticky; set when a start tick arrives while busy; cleared only by reset.

## Operation
- Reset values:
  - `adc_cs_n`=1, `adc_sclk`=0.
  - `sample`=0, `sample_valid`=0, `busy`=0, `overrun`=0.
  - Period counter=0, FSM=IDLE.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 and wraps to 0 while `enable`=1.
  - Forced to 0 while `enable`=0.
  - Start tick = `enable` && counter==0.
- FSM states: IDLE → SETUP → SHIFT_LO ⇄ SHIFT_HI → DONE → IDLE.
- IDLE: on a start tick, go to SETUP. `adc_cs_n` goes low and `busy` goes high at that edge.
- SETUP: hold for CLK_DIV cycles with `adc_sclk`=0, then go to SHIFT_LO.
- SHIFT_LO: `adc_sclk`=0 for CLK_DIV cycles. At the edge that raises `adc_sclk`, shift `adc_dout` into the shift register and increment the bit counter.
- SHIFT_HI: `adc_sclk`=1 for CLK_DIV cycles.
  - After the FRAME_BITS-th high phase, go to DONE.
  - Otherwise return to SHIFT_LO.
- DONE (single edge):
  - `adc_sclk`=0, `adc_cs_n`=1, `busy`=0.
  - `sample` loads the low DATA_BITS of the shift register, formatted per Configuration.
  - `sample_valid`=1 for exactly one cycle.
  - Return to IDLE.
- Leading FRAME_BITS−DATA_BITS bits are shifted in and then discarded.
- A start tick while not IDLE is dropped, and `overrun` is set. The legal SAMPLE_PERIOD bound makes this unreachable; it is a parameter-misuse detector.
- `enable` falling mid-frame: the frame completes and strobes normally; no further starts.
- `reset` mid-frame: the frame is aborted. All outputs take their reset values at that edge, and no `sample_valid` is issued.

## Timing
- `sample_valid` fires at edge E0 + CLK_DIV + 2*CLK_DIV*FRAME_BITS, where E0 is the edge at which `adc_cs_n` falls. With the default parameters this is E0+66.
- The start edge E0 is one cycle after the counter==0 cycle is sampled. The first E0 after `enable` rises is therefore the first clock edge with `enable`=1.
- Consecutive E0s are SAMPLE_PERIOD cycles apart.
- `adc_sclk` period is 2*CLK_DIV cycles with 50% duty; it is glitch-free because it is registered.
- `adc_dout` is sampled on the SHIFT_LO→SHIFT_HI edge, i.e. CLK_DIV cycles after the previous falling `adc_sclk`.
- `sample` stays stable between strobes.

## Configuration
- `MIC_ADC_TWOS_COMP_EN` defined:
  - The ADC word is treated as offset binary: its MSB is inverted, then the word is sign-extended to WIDTH.
  - Examples: 12'h800→0; 12'hFFF→32'h000007FF; 12'h000→32'hFFFFF800.
- Undefined: the ADC word is zero-extended to WIDTH, e.g. 12'h000→0 and 12'hFFF→32'h00000FFF.

## Structure
- `mic_pkg` holds:
  - the FSM state enum typedef `mic_adc_state_t`;
  - default constants `MIC_SAMPLE_WIDTH`=32, `MIC_ADC_BITS`=12, `MIC_FRAME_BITS`=16.
- One sub-module, `mic_sclk_gen`: the half-period counter. It outputs `phase_done` and the registered `adc_sclk`, and the FSM enables it only in SHIFT_LO/SHIFT_HI.
- Period counter, bit counter, shift register and output formatting live in the top.

## Test plan
- Reset release, then `enable`=1 with the ADC model returning frame 16'h0ABC:
  - `adc_cs_n` falls at the first enabled edge;
  - 16 `adc_sclk` pulses of 4 cycles each;
  - `sample_valid` pulse at E0+66 with `sample`=32'h00000ABC (macro off).
- Same run with `MIC_ADC_TWOS_COMP_EN` and frames 12'h800, 12'hFFF, 12'h000 → `sample`= 0, 32'h000007FF, 32'hFFFFF800.
- Free-running for 5 frames: E0 spacing exactly 100 cycles, 5 valid pulses, `overrun`=0, leading 4 bits ignored when the ADC model drives them to 1.
- `enable` dropped at E0+20: the frame completes with a valid pulse at E0+66; no further `adc_cs_n` fall for 300 cycles.
- `reset` asserted at E0+30: next edge `adc_cs_n`=1, `adc_sclk`=0, `busy`=0; no `sample_valid`; `sample`=0.
- Illegal SAMPLE_PERIOD=40 (CLK_DIV=2, FRAME_BITS=16): the second tick is dropped and `overrun` goes to 1 and stays 1 until reset.
